// File: rtl/bcd_down_counter_pkg.sv
// Shared definitions for the BCD down-counter: FSM state encoding, the
// largest legal BCD digit and a per-digit clamp used on parallel load.
package bcd_down_counter_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_RUN     = 2'b01,
      S_EXPIRED = 2'b10
   } state_e;

   localparam logic [3:0] BCD_MAX = 4'd9;

   // Values above 9 are not BCD; saturate them to 9 so count stays legal.
   function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

endpackage

// File: rtl/bcd_down_counter_if.sv
// Control/status bundle of the BCD down-counter.
//   load, load_value, enable, auto_reload : controller -> counter
//   count, zero, expire, busy             : counter -> controller
// master = controller side, slave = counter side.
interface bcd_down_counter_if #(
   parameter int DIGITS = 2
) ();
   logic                  load;
   logic [4*DIGITS-1:0]   load_value;
   logic                  enable;
   logic                  auto_reload;
   logic [4*DIGITS-1:0]   count;
   logic                  zero;
   logic                  expire;
   logic                  busy;

   modport master (
      output load, load_value, enable, auto_reload,
      input  count, zero, expire, busy
   );

   modport slave (
      input  load, load_value, enable, auto_reload,
      output count, zero, expire, busy
   );
endinterface

// File: rtl/bcd_down_counter_digit.sv
// One BCD digit of the decrement chain (purely combinational).
//   digit      : current digit value (0..9)
//   borrow_in  : decrement request from the less significant side
//   next_digit : digit after the step
//   borrow_out : request passed to the more significant digit
module bcd_down_digit
   import bcd_down_counter_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       borrow_in,
   output logic [3:0] next_digit,
   output logic       borrow_out
);
   assign borrow_out = borrow_in & (digit == 4'd0);

   always_comb begin
      next_digit = digit;
      if (borrow_in) begin
         next_digit = (digit == 4'd0) ? BCD_MAX : digit - 4'd1;
      end
   end
endmodule

// File: rtl/bcd_down_counter.sv
// Cascaded DIGITS-digit BCD down-counter with parallel load, count enable
// and optional auto-reload. Flags underflow with a one-cycle expire pulse.
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : control/status bundle (slave side), see bcd_down_counter_if
module bcd_down_counter
   import bcd_down_counter_pkg::*;
#(
   parameter int DIGITS = 2
) (
   input  logic              clock,
   input  logic              reset,
   bcd_down_counter_if.slave bus
);
   localparam int W = 4 * DIGITS;

   state_e         state_q, state_d;
   logic [W-1:0]   count_q, count_d;
   logic [W-1:0]   reload_q, reload_d;
   logic           expire_q, expire_d;

   logic [W-1:0]   load_clamped;
   logic [W-1:0]   count_dec;
   logic [DIGITS:0] borrow;
   logic           count_is_zero;

   // The chain is always asked to decrement; whether the result is used
   // is decided by the FSM below.
   assign borrow[0] = 1'b1;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_down_digit u_digit (
         .digit      (count_q[4*g +: 4]),
         .borrow_in  (borrow[g]),
         .next_digit (count_dec[4*g +: 4]),
         .borrow_out (borrow[g+1])
      );
      assign load_clamped[4*g +: 4] = bcd_clamp(bus.load_value[4*g +: 4]);
   end

   // A borrow leaves the top digit only when every digit is 0.
   assign count_is_zero = borrow[DIGITS];

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      expire_d = 1'b0;

      if (bus.load) begin
         // Load wins over enable and is accepted in every state.
         count_d  = load_clamped;
         reload_d = load_clamped;
         state_d  = S_RUN;
      end else begin
         unique case (state_q)
            S_IDLE:    state_d = S_IDLE;
            S_RUN: begin
               if (bus.enable) begin
                  if (count_is_zero) begin
                     expire_d = 1'b1;
                     if (bus.auto_reload) begin
                        count_d = reload_q;
                     end else begin
                        state_d = S_EXPIRED;
                     end
                  end else begin
                     count_d = count_dec;
                  end
               end
            end
            S_EXPIRED: state_d = S_EXPIRED;
            default:   state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         count_q  <= '0;
         reload_q <= '0;
         expire_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         expire_q <= expire_d;
      end
   end

   assign bus.count  = count_q;
   assign bus.zero   = count_is_zero;
   assign bus.expire = expire_q;
   assign bus.busy   = (state_q == S_RUN);
endmodule

// File: tb/tb_bcd_down_counter.sv
// Scoreboard bench for bcd_down_counter: the driver steps an integer-level
// reference model and queues the expected outputs; the monitor pops and
// compares after every rising edge.
module tb_bcd_down_counter;
   localparam int DIGITS = 2;
   localparam int W      = 4 * DIGITS;

   typedef struct {
      logic [W-1:0] count;
      logic         zero;
      logic         expire;
      logic         busy;
   } exp_t;

   logic clock;
   logic reset;

   bcd_down_counter_if #(.DIGITS(DIGITS)) bus ();

   bcd_down_counter #(.DIGITS(DIGITS)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int fails  = 0;
   exp_t exp_q[$];

   // Reference model: count and reload kept as plain integers.
   int m_cnt, m_rel, m_state; // m_state: 0 idle, 1 running, 2 expired
   bit m_exp;

   function automatic int bcd_to_int(input logic [W-1:0] v);
      int r = 0;
      int p = 1;
      for (int i = 0; i < DIGITS; i++) begin
         int d = int'(v[4*i +: 4]);
         if (d > 9) d = 9;
         r += d * p;
         p *= 10;
      end
      return r;
   endfunction

   function automatic logic [W-1:0] int_to_bcd(input int v);
      logic [W-1:0] r = '0;
      int x = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.count  = int_to_bcd(m_cnt);
      e.zero   = (m_cnt == 0);
      e.expire = m_exp;
      e.busy   = (m_state == 1);
      return e;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic cyc(input logic ld, input logic [W-1:0] lv, input logic en, input logic ar);
      @(negedge clock);
      reset           = 1'b1;
      bus.load        = ld;
      bus.load_value  = lv;
      bus.enable      = en;
      bus.auto_reload = ar;
      m_exp = 1'b0;
      if (ld) begin
         m_cnt   = bcd_to_int(lv);
         m_rel   = m_cnt;
         m_state = 1;
      end else if (m_state == 1 && en) begin
         if (m_cnt == 0) begin
            m_exp = 1'b1;
            if (ar) m_cnt = m_rel;
            else    m_state = 2;
         end else begin
            m_cnt = m_cnt - 1;
         end
      end
      exp_q.push_back(model_out());
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset          = 1'b0;
      bus.load       = 1'b0;
      bus.enable     = 1'b0;
      #1;
      chk("rst_count",  bus.count,  '0);
      chk("rst_zero",   W'(bus.zero),   W'(1));
      chk("rst_busy",   W'(bus.busy),   W'(0));
      chk("rst_expire", W'(bus.expire), W'(0));
      m_cnt = 0; m_rel = 0; m_state = 0; m_exp = 1'b0;
      exp_q.push_back(model_out());
   endtask

   task automatic settle();
      @(posedge clock);
      #2;
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("count",  bus.count,      e.count);
            chk("zero",   W'(bus.zero),   W'(e.zero));
            chk("expire", W'(bus.expire), W'(e.expire));
            chk("busy",   W'(bus.busy),   W'(e.busy));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0;
      bus.load = 1'b0; bus.load_value = '0; bus.enable = 1'b0; bus.auto_reload = 1'b0;
      m_cnt = 0; m_rel = 0; m_state = 0; m_exp = 1'b0;
      do_reset();

      // Reset mid-run
      cyc(1'b1, 8'h25, 1'b0, 1'b0);
      repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
      settle();
      chk("mid_run_22", bus.count, 8'h22);
      do_reset();
      repeat (5) cyc(1'b0, '0, 1'b1, 1'b0);
      settle();
      chk("idle_after_reset", bus.count, 8'h00);

      // One-shot
      cyc(1'b1, 8'h12, 1'b0, 1'b0);
      repeat (12) cyc(1'b0, '0, 1'b1, 1'b0);
      settle();
      chk("oneshot_at_00", bus.count, 8'h00);
      cyc(1'b0, '0, 1'b1, 1'b0);
      settle();
      chk("oneshot_expire", W'(bus.expire), W'(1));
      chk("oneshot_busy",   W'(bus.busy),   W'(0));
      repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);

      // Digit borrow
      cyc(1'b1, 8'h30, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      settle();
      chk("borrow_29", bus.count, 8'h29);
      cyc(1'b1, 8'h10, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      settle();
      chk("borrow_09", bus.count, 8'h09);
      cyc(1'b1, 8'h00, 1'b0, 1'b1);
      cyc(1'b0, '0, 1'b1, 1'b1);
      settle();
      chk("load0_expire", W'(bus.expire), W'(1));

      // Auto-reload
      cyc(1'b1, 8'h03, 1'b0, 1'b1);
      repeat (12) cyc(1'b0, '0, 1'b1, 1'b1);

      // Load priority and clamp
      cyc(1'b1, 8'h9F, 1'b1, 1'b0);
      settle();
      chk("clamp_99", bus.count, 8'h99);
      cyc(1'b0, '0, 1'b1, 1'b0);
      settle();
      chk("after_clamp_98", bus.count, 8'h98);

      // Enable gaps
      cyc(1'b1, 8'h05, 1'b0, 1'b0);
      for (int i = 0; i < 14; i++) cyc(1'b0, '0, (i % 2 == 0), 1'b0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            cyc(($urandom_range(0, 15) == 0), W'($urandom), ($urandom_range(0, 3) != 0),
                1'($urandom));
         end
      end

      settle();
      chk("queue_drained", W'(exp_q.size()), W'(0));
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule

// File: doc/bcd_down_counter.md
Name: bcd_down_counter

Overview:
- Synchronous, cascaded multi-digit BCD down-counter with parallel load, count enable and optional auto-reload.
- Complements the team's up-counters: counts toward zero instead of away from it.
- Flags terminal count with a single-cycle expire pulse.
- Used as a countdown/interval timer feeding control FSMs and display logic.

Parameters:
- DIGITS, 2, number of BCD digits; count width is 4*DIGITS.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- load  input  1  parallel-load strobe; sampled on clock rising edge.
- load_value  input  4*DIGITS  BCD value to load; digit[3:0] is least significant.
- enable  input  1  count-step qualifier; one decrement per clock edge while high.
- auto_reload  input  1  1 = reload on underflow; 0 = one-shot.
- count  output  4*DIGITS  current BCD count (registered).
- zero  output  1  combinational; high when count == 0.
- expire  output  1  registered one-cycle pulse on underflow event.
- busy  output  1  high while FSM is in RUN.

Behaviour:
- Reset (reset == 0, asynchronous, immediate):
  - count = 0, reload register = 0, expire = 0, FSM = IDLE.
  - Therefore zero = 1 and busy = 0.
  - Reset asserted mid-count aborts the count immediately; no expire pulse is generated.
- FSM states: IDLE, RUN, EXPIRED.
  - IDLE: enable is ignored and count holds. load -> RUN.
  - RUN: handles enable steps as described below. load -> RUN, with a new value.
  - EXPIRED: count holds 0 and enable is ignored. load -> RUN.
- Load:
  - On a rising edge with load = 1, count and the reload register both take load_value.
  - Any digit > 9 is clamped to 9 per digit; e.g. 4'hF loads as 4'h9.
  - Load has priority over enable on the same edge; no decrement occurs that cycle.
  - Load is accepted in every state.
  - Loading 0 enters RUN; the next enabled edge is an underflow.
- Decrement (RUN, enable = 1, load = 0, count != 0):
  - Least significant digit decrements by one.
  - A digit at 0 wraps to 9 and borrows from the next digit.
  - Borrow ripples combinationally within the same cycle.
  - All digits update on the same edge; latency is 1 cycle.
- Underflow (RUN, enable = 1, load = 0, count == 0):
  - expire = 1 for exactly the following cycle.
  - If auto_reload = 1: count <= reload register and FSM stays RUN. The period is N+1 enabled edges for loaded value N.
  - If auto_reload = 0: count stays 0 and FSM -> EXPIRED.
  - auto_reload is sampled only at the underflow edge.
- enable = 0 in RUN: count holds and expire = 0.
- expire is never high for two consecutive cycles unless an underflow occurs on consecutive enabled edges (auto_reload with reload value 0).
- Maximum count is all-9s (99 for DIGITS = 2). Count never holds a non-BCD digit.

Decomposition:
- Shared package holds:
  - State encoding: S_IDLE = 2'b00, S_RUN = 2'b01, S_EXPIRED = 2'b10.
  - BCD_MAX = 4'd9.
- One sub-module, bcd_down_digit, instantiated DIGITS times via generate:
  - Inputs: digit[3:0], borrow_in.
  - Outputs: next_digit[3:0], borrow_out.
  - borrow_out = borrow_in & (digit == 0).
  - next_digit = 9 on wrap, digit-1 when borrowing, otherwise digit.
- Top module holds the FSM, count register, reload register, load clamp and expire register.

Test Plan:
- Reset mid-run, DIGITS = 2: load 8'h25, then 3 enabled edges -> count 8'h22. Pull reset low between edges -> count 8'h00, zero = 1, busy = 0 immediately, expire = 0. After release, enable = 1 for 5 edges -> count stays 00 (IDLE).
- One-shot, auto_reload = 0: load 8'h12, then continuous enable:
  - count 11, 10, 09 ... 00 after 12 edges.
  - 13th edge -> expire = 1 for one cycle, busy = 0, count holds 00.
  - Further enables -> no change.
- Digit borrow: load 8'h30, 1 enabled edge -> 8'h29. Load 8'h10, 1 enabled edge -> 8'h09. Load 8'h00 with auto_reload = 1, 1 enabled edge -> expire = 1, count 00.
- Auto-reload: load 8'h03, auto_reload = 1, continuous enable:
  - Sequence 03, 02, 01, 00, 03, 02, ...
  - expire = 1 only in the cycle after each 00 -> 03 edge (period 4 edges).
  - busy stays 1 throughout.
- Load priority and clamp: load = 1 and enable = 1 on the same edge with load_value 8'h9F -> count 8'h99, no decrement that cycle. Next enabled edge -> 8'h98.
- Enable gaps: load 8'h05, alternate enable 1/0 each cycle -> count decrements only on enabled edges: 04, 04, 03, 03 ... ; expire = 0 until underflow.
